bus_drv_arbiter: RTL and testbench

BUS_DRV_ARBITER -- requirements
Module: bus_drv_arbiter

---
 rtl/bus_drv_arbiter.sv | 122 ++++++++++++
 tb/tb_bus_drv_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_drv_arbiter.sv
// Round-robin owner of a shared 8-bit bus for four octal-driver sources: one-cycle grant latency, bounded hold.
// A waiting requester preempts the owner after MAX_HOLD cycles; dead TURN_CYC cycles separate owners.
module bus_drv_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int TURN_CYC = 1
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [3:0]  req,
    input  logic [31:0] din,
    output logic [3:0]  n_g,
    output logic [3:0]  gnt,
    output logic [7:0]  bus_out,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;

    localparam logic [7:0] HOLD_MAX  = 8'(MAX_HOLD);
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    localparam logic [3:0] TURN_LAST = 4'(TURN_CYC - 1);

    state_t     state;
    logic [1:0] last_owner;
    logic [7:0] hold_cnt;
    logic [3:0] turn_cnt;

    logic [1:0] winner;
    logic [1:0] cand;
    logic [3:0] win_oh;
    logic [3:0] owner_oh;
    logic       others;
    logic       expired;
    logic       release_bus;

    // Scan from farthest to nearest so the closest set bit after last_owner wins;
    // offset 4 wraps to last_owner itself, giving the previous owner lowest priority.
    always_comb begin
        winner = last_owner;
        cand   = '0;
        for (int i = 4; i >= 1; i--) begin
            cand = last_owner + 2'(i);
            if (req[cand]) winner = cand;
        end
    end

    assign win_oh      = 4'b0001 << winner;
    assign owner_oh    = 4'b0001 << last_owner;
    assign others      = |(req & ~owner_oh);
    // The counter reads MAX_HOLD-1 during the owner's MAX_HOLD-th cycle, and saturates above it.
    assign expired     = (hold_cnt >= HOLD_LAST);
    assign release_bus = !req[last_owner] || (expired && others);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state      <= IDLE;
            last_owner <= 2'd3;
            hold_cnt   <= '0;
            turn_cnt   <= '0;
            gnt        <= '0;
            n_g        <= '1;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        state      <= OWN;
                        last_owner <= winner;
                        hold_cnt   <= '0;
                        gnt        <= win_oh;
                        n_g        <= ~win_oh;
                        busy       <= 1'b1;
                    end
                end
                OWN: begin
                    if (release_bus) begin
                        state    <= TURN;
                        turn_cnt <= '0;
                        gnt      <= '0;
                        n_g      <= '1;
                    end else if (hold_cnt != HOLD_MAX) begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                TURN: begin
                    if (turn_cnt == TURN_LAST) begin
                        if (|req) begin
                            state      <= OWN;
                            last_owner <= winner;
                            hold_cnt   <= '0;
                            gnt        <= win_oh;
                            n_g        <= ~win_oh;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        turn_cnt <= turn_cnt + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    n_g   <= '1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Unregistered so data from the granted source reaches the bus in the same cycle.
    always_comb begin
        case (gnt)
            4'b0001: bus_out = din[7:0];
            4'b0010: bus_out = din[15:8];
            4'b0100: bus_out = din[23:16];
            4'b1000: bus_out = din[31:24];
            default: bus_out = 8'hFF;
        endcase
    end

endmodule

// File: tb/tb_bus_drv_arbiter.sv
// Scoreboard bench for bus_drv_arbiter at default MAX_HOLD=16, TURN_CYC=1.
module tb_bus_drv_arbiter;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] din = {8'h78, 8'h34, 8'h56, 8'h12};
    logic [3:0]  n_g;
    logic [3:0]  gnt;
    logic [7:0]  bus_out;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [3:0] g;
        logic       b;
    } exp_t;

    exp_t sb[$];

    bus_drv_arbiter dut (
        .clk     (clk),
        .n_reset (n_reset),
        .req     (req),
        .din     (din),
        .n_g     (n_g),
        .gnt     (gnt),
        .bus_out (bus_out),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_bus(input logic [3:0] g);
        case (g)
            4'b0001: return din[7:0];
            4'b0010: return din[15:8];
            4'b0100: return din[23:16];
            4'b1000: return din[31:24];
            default: return 8'hFF;
        endcase
    endfunction

    // Applies req for one cycle and records what must be visible after the edge.
    task automatic drive(input logic [3:0] r, input logic [3:0] eg, input logic eb);
        exp_t e;
        e.g = eg;
        e.b = eb;
        req = r;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        req     = '0;
        n_reset = 1'b0;
        @(posedge clk);
        #1;
        n_reset = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        n_reset = 1'b0;
        req     = 4'b1111;
        @(posedge clk);
        #1;
        vectors++;
        if (gnt !== 4'h0 || n_g !== 4'hF || busy !== 1'b0 || bus_out !== 8'hFF) begin
            miscompares++;
            $display("FAIL reset_hold: gnt=%b n_g=%b busy=%b bus=%h, want 0000 1111 0 ff", gnt, n_g, busy, bus_out);
        end
        req     = '0;
        n_reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(4'b0000, 4'b0000, 1'b0);
            e = sb.pop_front();
            vectors++;
            if (gnt !== e.g || n_g !== ~e.g || busy !== e.b || bus_out !== exp_bus(e.g)) begin
                miscompares++;
                $display("FAIL idle_no_req cyc %0d: gnt=%b n_g=%b busy=%b bus=%h, want gnt=%b busy=%b bus=%h",
                         i, gnt, n_g, busy, bus_out, e.g, e.b, exp_bus(e.g));
            end
        end
    endtask

    // Source 0 wins first, keeps req for 16 OWN cycles, then yields to waiting source 2.
    task automatic test_hold_expiry();
        exp_t       e;
        logic [3:0] eg;
        logic       eb;
        apply_reset();
        din = {8'h78, 8'h34, 8'h56, 8'h12};
        for (int c = 0; c < 18; c++) begin
            eg = (c < 16) ? 4'b0001 : (c == 16) ? 4'b0000 : 4'b0100;
            eb = 1'b1;
            drive(4'b0101, eg, eb);
            e = sb.pop_front();
            vectors++;
            if (gnt !== e.g || n_g !== ~e.g || busy !== e.b || bus_out !== exp_bus(e.g)) begin
                miscompares++;
                $display("FAIL hold_expiry cyc %0d: gnt=%b n_g=%b busy=%b bus=%h, want gnt=%b busy=%b bus=%h",
                         c, gnt, n_g, busy, bus_out, e.g, e.b, exp_bus(e.g));
            end
        end
        vectors++;
        if (bus_out !== 8'h34) begin
            miscompares++;
            $display("FAIL hold_expiry_data: bus=%h, want 34", bus_out);
        end
    endtask

    // Lone source 3 keeps the bus past saturation; a late competitor still preempts it.
    task automatic test_saturate();
        exp_t       e;
        logic [3:0] r;
        logic [3:0] eg;
        logic       eb;
        apply_reset();
        for (int c = 0; c < 44; c++) begin
            din[31:24] = 8'($urandom);
            din[7:0]   = 8'($urandom);
            if (c < 40) begin
                r = 4'b1000; eg = 4'b1000; eb = 1'b1;
            end else if (c == 40) begin
                r = 4'b1001; eg = 4'b0000; eb = 1'b1;
            end else if (c == 41) begin
                r = 4'b1001; eg = 4'b0001; eb = 1'b1;
            end else if (c == 42) begin
                r = 4'b0000; eg = 4'b0000; eb = 1'b1;
            end else begin
                r = 4'b0000; eg = 4'b0000; eb = 1'b0;
            end
            drive(r, eg, eb);
            e = sb.pop_front();
            vectors++;
            if (gnt !== e.g || n_g !== ~e.g || busy !== e.b || bus_out !== exp_bus(e.g)) begin
                miscompares++;
                $display("FAIL saturate cyc %0d: gnt=%b n_g=%b busy=%b bus=%h, want gnt=%b busy=%b bus=%h",
                         c, gnt, n_g, busy, bus_out, e.g, e.b, exp_bus(e.g));
            end
        end
        din = {8'h78, 8'h34, 8'h56, 8'h12};
    endtask

    // Owner 1 drops req in its last allowed cycle while source 2 waits: a single TURN.
    task automatic test_drop_at_expiry();
        exp_t       e;
        logic [3:0] r;
        logic [3:0] eg;
        logic       eb;
        apply_reset();
        for (int c = 0; c < 20; c++) begin
            r  = (c < 16) ? 4'b0110 : (c < 18) ? 4'b0100 : 4'b0000;
            eg = (c < 16) ? 4'b0010 : (c == 16) ? 4'b0000 : (c == 17) ? 4'b0100 : 4'b0000;
            eb = (c < 19);
            drive(r, eg, eb);
            e = sb.pop_front();
            vectors++;
            if (gnt !== e.g || n_g !== ~e.g || busy !== e.b || bus_out !== exp_bus(e.g)) begin
                miscompares++;
                $display("FAIL drop_at_expiry cyc %0d: gnt=%b n_g=%b busy=%b bus=%h, want gnt=%b busy=%b bus=%h",
                         c, gnt, n_g, busy, bus_out, e.g, e.b, exp_bus(e.g));
            end
        end
    endtask

    task automatic test_reset_mid_own();
        exp_t       e;
        logic [3:0] r;
        logic [3:0] eg;
        logic       eb;
        apply_reset();
        for (int c = 0; c < 3; c++) begin
            drive(4'b0010, 4'b0010, 1'b1);
            e = sb.pop_front();
            vectors++;
            if (gnt !== e.g || n_g !== ~e.g || busy !== e.b || bus_out !== exp_bus(e.g)) begin
                miscompares++;
                $display("FAIL pre_reset_own cyc %0d: gnt=%b n_g=%b busy=%b bus=%h, want gnt=%b busy=%b",
                         c, gnt, n_g, busy, bus_out, e.g, e.b);
            end
        end
        #2;
        n_reset = 1'b0;
        #1;
        vectors++;
        if (n_g !== 4'hF || gnt !== 4'h0 || bus_out !== 8'hFF || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: n_g=%b gnt=%b bus=%h busy=%b, want 1111 0000 ff 0", n_g, gnt, bus_out, busy);
        end
        @(posedge clk);
        #1;
        n_reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            r  = (c < 2) ? 4'b0010 : 4'b0000;
            eg = (c < 2) ? 4'b0010 : 4'b0000;
            eb = (c < 3);
            drive(r, eg, eb);
            e = sb.pop_front();
            vectors++;
            if (gnt !== e.g || n_g !== ~e.g || busy !== e.b || bus_out !== exp_bus(e.g)) begin
                miscompares++;
                $display("FAIL post_reset cyc %0d: gnt=%b n_g=%b busy=%b bus=%h, want gnt=%b busy=%b bus=%h",
                         c, gnt, n_g, busy, bus_out, e.g, e.b, exp_bus(e.g));
            end
        end
    endtask

    // All sources requesting: 16-cycle tenures in order 0,1,2,3,0 with one dead cycle between.
    task automatic test_round_robin();
        exp_t       e;
        logic [3:0] eg;
        int         slot;
        apply_reset();
        for (int c = 0; c < 17 * 4 + 2; c++) begin
            slot = c % 17;
            eg   = (slot == 16) ? 4'b0000 : (4'b0001 << ((c / 17) % 4));
            drive(4'b1111, eg, 1'b1);
            e = sb.pop_front();
            vectors++;
            if (gnt !== e.g || n_g !== ~e.g || busy !== e.b || bus_out !== exp_bus(e.g)) begin
                miscompares++;
                $display("FAIL round_robin cyc %0d: gnt=%b n_g=%b busy=%b bus=%h, want gnt=%b busy=%b bus=%h",
                         c, gnt, n_g, busy, bus_out, e.g, e.b, exp_bus(e.g));
            end
            vectors++;
            if ($countones(~n_g) > 1) begin
                miscompares++;
                $display("FAIL one_driver cyc %0d: n_g=%b, want at most one low bit", c, n_g);
            end
        end
    endtask

    initial begin
        test_reset();
        test_hold_expiry();
        test_saturate();
        test_drop_at_expiry();
        test_reset_mid_own();
        test_round_robin();
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
